// File: rtl/dmem_responder_if.sv
// dmem_responder_if: memory-stage to data-memory bus; the memory stage is the master.
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address_dmem;
    logic [DATA_WIDTH-1:0] d_dmem;
    logic                  wren;
    logic [DATA_WIDTH-1:0] q_dmem;
    logic                  ready;
    logic [DATA_WIDTH-1:0] io_out;
    modport master (output address_dmem, d_dmem, wren, input q_dmem, ready, io_out);
    modport slave (input address_dmem, d_dmem, wren, output q_dmem, ready, io_out);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: zero-filled data RAM with 1-cycle registered reads, an io_out register and a cycle counter.
module dmem_responder #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4094,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR    = 12'hFFE,
    parameter logic [ADDR_WIDTH-1:0] CYCLE_ADDR = 12'hFFF
) (
    input logic              clock,
    input logic              reset_n,
    dmem_responder_if.slave  bus
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [31:0]           cycle_cnt_q;
    logic [DATA_WIDTH-1:0] q_q, io_q, q_d;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  is_io, is_cyc, is_ram, run, ram_we, mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    always_comb begin
        run    = state_q == RUN;
        is_io  = bus.address_dmem == IO_ADDR;
        is_cyc = bus.address_dmem == CYCLE_ADDR;
        is_ram = {1'b0, bus.address_dmem} < (ADDR_WIDTH+1)'(DEPTH);
        ram_we = run && bus.wren && !is_io && !is_cyc && is_ram;
        // the fill pass owns the write port until RUN
        mem_we = !run || ram_we;
        mem_wa = run ? bus.address_dmem : clr_addr_q;
        mem_wd = run ? bus.d_dmem : '0;
        q_d    = is_io  ? (bus.wren ? bus.d_dmem : io_q) :
                 is_cyc ? DATA_WIDTH'(cycle_cnt_q) :
                 is_ram ? (bus.wren ? bus.d_dmem : mem[bus.address_dmem]) : '0;
    end
    always_ff @(posedge clock)
        if (mem_we) mem[mem_wa] <= mem_wd;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            cycle_cnt_q <= '0;
            q_q         <= '0;
            io_q        <= '0;
            ready_q     <= 1'b0;
        end else if (state_q == CLEAR) begin
            clr_addr_q <= clr_addr_q + 1'b1;
            if (clr_addr_q == LAST) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end else begin
            q_q         <= q_d;
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (bus.wren && is_io) io_q <= bus.d_dmem;
        end
    end
    assign bus.q_dmem = q_q;
    assign bus.io_out = io_q;
    assign bus.ready  = ready_q;
endmodule
